// File: rtl/mul_acc_seq.sv
// Sequential radix-2 shift-and-add multiply-accumulator: P = A*B + C, one multiplier bit per clock.
// Sized to mirror the non-restoring divider (quotient A, divisor B, remainder C -> dividend P).
module mul_acc_seq #(
  parameter int Nx = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [Nx-1:0]   A,
  input  logic [Nx-2:0]   B,
  input  logic [2*Nx-3:0] C,
  output logic            busy,
  output logic            done,
  output logic [2*Nx-1:0] P
);
  localparam int PW = 2 * Nx;
  localparam int CW = $clog2(Nx + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [Nx-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d;
  logic [PW-1:0]   sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  // Partial product is shifted by the iteration count; mcand itself stays put.
  assign sum = acc_q + (mplier_q[0] ? (mcand_q << cnt_q) : '0);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = PW'(C);
          mcand_d  = PW'(B);
          mplier_d = A;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = sum;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(Nx - 1)) begin
          p_d     = sum;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign P    = p_q;

endmodule
